yarp_mc_control: RTL
====================

YARP_MC_CONTROL -- requirements
Module: yarp_mc_control

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum wait cycles for a grant in FETCH or MEM.
REQ-002 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 is_r/i/s/b/u/j_type_i  in  1 each  one-hot instruction type from the decoder.
REQ-006 instr_funct3_i / instr_funct7_bit5_i / instr_opcode_i  in  3/1/7  instruction fields, valid from DECODE onward.
REQ-007 branch_taken_i  in  1  branch comparator result, sampled in EXEC.
REQ-008 instr_req_o / instr_gnt_i  out/in  1/1  instruction-fetch request and grant.
REQ-009 data_req_o / data_gnt_i  out/in  1/1  data-memory request and grant.
REQ-010 pc_sel_o, op1sel_o, op2sel_o, data_wr_o, zero_extnd_o  out  1 each  datapath controls, same meaning as the single-cycle control unit.
REQ-011 alu_func_o / rf_wr_data_o / data_byte_o  out  4/2/2  yarp_pkg encodings (OP_*, Alu/Mem/Imm/Pc, Byte/Half/Word).
REQ-012 rf_wr_en_o / pc_wr_en_o / ir_wr_en_o  out  1 each  register-file, PC and IR write strobes.
REQ-013 state_o  out  3  current FSM state; fault_o  out  1  sticky trap flag; retire_cnt_o  out  CNT_W  retired instructions.

Function
REQ-014 FSM states: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
REQ-015 FETCH: instr_req_o=1 until instr_gnt_i; the grant cycle pulses ir_wr_en_o and moves to DECODE.
REQ-016 DECODE (1 cycle): derive the control word with single-cycle semantics and register it; illegal instruction -> TRAP.
REQ-017 An instruction is illegal if no is_*_type_i is set or more than one is set, if a load has funct3 of 3, 6 or 7, or if a store has funct3 above 2.
REQ-018 The registered control word drives pc_sel_o, op1sel_o, op2sel_o, alu_func_o, rf_wr_data_o, data_byte_o, data_wr_o and zero_extnd_o from EXEC until the return to FETCH; these outputs are 0 in FETCH and DECODE.
REQ-019 EXEC (1 cycle) transitions:
- load or store -> MEM
- R/I/U/J type or JALR -> WB
- B type -> FETCH with pc_wr_en_o=1 and pc_sel_o=branch_taken_i.
REQ-020 MEM: data_req_o=1 until data_gnt_i; on grant, a store goes to FETCH with pc_wr_en_o=1 and a load goes to WB.
REQ-021 WB (1 cycle): rf_wr_en_o=1 and pc_wr_en_o=1, then FETCH.
REQ-022 rf_wr_en_o is asserted only in WB, data_req_o only in MEM, instr_req_o only in FETCH; each strobe is high for exactly one cycle per instruction.
REQ-023 retire_cnt_o increments on every cycle with pc_wr_en_o=1 and wraps from all-ones to 0 without a flag.
REQ-024 TRAP: all strobes and requests 0, fault_o=1, state held until reset; the retire count is frozen.
REQ-025 A grant arriving while its request is low is ignored.

Reset
REQ-026 On reset: state=FETCH, control word=0, fault_o=0, retire_cnt_o=0, wait counter=0; all outputs 0 except instr_req_o, which is 1 in the first cycle after reset.
REQ-027 Reset asserted mid-instruction (including during MEM with data_req_o high) aborts it: no rf/pc write, and the counter does not increment.
REQ-028 Reset has priority over every other event in the same cycle.

Configuration
REQ-029 Macro YARP_MC_TIMEOUT_EN:
- Defined: a wait counter clears on entering FETCH or MEM and increments each cycle without a grant; if it reaches TIMEOUT_CYCLES with no grant, the next state is TRAP, and a grant in that same cycle wins.
- Undefined: no counter; FETCH and MEM wait indefinitely.

Verification
REQ-030 ADD (R type), grants immediate -> states 0,1,2,4,0; alu_func_o=OP_ADD in EXEC/WB; one rf_wr_en_o pulse; retire_cnt_o 0->1.
REQ-031 LW with data_gnt_i delayed 3 cycles -> data_req_o high 4 cycles, data_byte_o=Word, rf_wr_data_o=Mem, then WB; total 8 cycles.
REQ-032 BEQ with branch_taken_i=1 -> in EXEC, pc_wr_en_o=1, pc_sel_o=1, op1sel_o=1, no rf_wr_en_o; returns to FETCH.
REQ-033 S type with funct3=3 -> TRAP after DECODE, fault_o=1, no data_req_o; reset -> FETCH, fault_o=0.
REQ-034 YARP_MC_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, instr_gnt_i held 0 -> TRAP after 4 cycles of FETCH; undefined -> FETCH held for 100 cycles.
REQ-035 Reset pulsed during MEM of SW -> no pc_wr_en_o, retire_cnt_o=0, instr_req_o=1 in the next cycle.

Source files
------------

// File: rtl/yarp_mc_control.sv
// Multi-cycle control FSM for the YARP core: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP state.
// Optional grant timeout enabled by defining YARP_MC_TIMEOUT_EN.
module yarp_mc_control #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             is_r_type_i,
    input  logic             is_i_type_i,
    input  logic             is_s_type_i,
    input  logic             is_b_type_i,
    input  logic             is_u_type_i,
    input  logic             is_j_type_i,
    input  logic [2:0]       instr_funct3_i,
    input  logic             instr_funct7_bit5_i,
    input  logic [6:0]       instr_opcode_i,
    input  logic             branch_taken_i,
    output logic             instr_req_o,
    input  logic             instr_gnt_i,
    output logic             data_req_o,
    input  logic             data_gnt_i,
    output logic             pc_sel_o,
    output logic             op1sel_o,
    output logic             op2sel_o,
    output logic             data_wr_o,
    output logic             zero_extnd_o,
    output logic [3:0]       alu_func_o,
    output logic [1:0]       rf_wr_data_o,
    output logic [1:0]       data_byte_o,
    output logic             rf_wr_en_o,
    output logic             pc_wr_en_o,
    output logic             ir_wr_en_o,
    output logic [2:0]       state_o,
    output logic             fault_o,
    output logic [CNT_W-1:0] retire_cnt_o
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SRL  = 4'd3;
    localparam logic [3:0] OP_SRA  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_SLTU = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;

    localparam logic [1:0] RF_ALU = 2'd0;
    localparam logic [1:0] RF_MEM = 2'd1;
    localparam logic [1:0] RF_IMM = 2'd2;
    localparam logic [1:0] RF_PC  = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b11;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    typedef struct packed {
        logic       pc_sel;
        logic       op1sel;
        logic       op2sel;
        logic [3:0] alu_func;
        logic [1:0] rf_wr_data;
        logic [1:0] data_byte;
        logic       data_wr;
        logic       zero_extnd;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
    } ctrl_t;

    state_t           state;
    ctrl_t            ctrl;
    ctrl_t            ctrl_d;
    logic             illegal;
    logic             timeout;
    logic             show_ctrl;
    logic [CNT_W-1:0] retire_cnt;

    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic b5, input logic allow_sub);
        case (f3)
            3'b000:  return (allow_sub && b5) ? OP_SUB : OP_ADD;
            3'b001:  return OP_SLL;
            3'b010:  return OP_SLT;
            3'b011:  return OP_SLTU;
            3'b100:  return OP_XOR;
            3'b101:  return b5 ? OP_SRA : OP_SRL;
            3'b110:  return OP_OR;
            default: return OP_AND;
        endcase
    endfunction

    function automatic logic [1:0] mem_size(input logic [1:0] f3lo);
        case (f3lo)
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    always_comb begin
        ctrl_d  = '0;
        illegal = ($countones({is_r_type_i, is_i_type_i, is_s_type_i,
                               is_b_type_i, is_u_type_i, is_j_type_i}) != 1);
        if (is_r_type_i) begin
            ctrl_d.alu_func   = alu_op(instr_funct3_i, instr_funct7_bit5_i, 1'b1);
            ctrl_d.rf_wr_data = RF_ALU;
        end else if (is_i_type_i) begin
            ctrl_d.op2sel = 1'b1;
            if (instr_opcode_i == OPC_LOAD) begin
                ctrl_d.is_load    = 1'b1;
                ctrl_d.alu_func   = OP_ADD;
                ctrl_d.rf_wr_data = RF_MEM;
                ctrl_d.data_byte  = mem_size(instr_funct3_i[1:0]);
                ctrl_d.zero_extnd = instr_funct3_i[2];
                if (instr_funct3_i == 3'd3 || instr_funct3_i == 3'd6 || instr_funct3_i == 3'd7)
                    illegal = 1'b1;
            end else if (instr_opcode_i == OPC_JALR) begin
                ctrl_d.pc_sel     = 1'b1;
                ctrl_d.alu_func   = OP_ADD;
                ctrl_d.rf_wr_data = RF_PC;
            end else begin
                ctrl_d.alu_func   = alu_op(instr_funct3_i, instr_funct7_bit5_i, 1'b0);
                ctrl_d.rf_wr_data = RF_ALU;
            end
        end else if (is_s_type_i) begin
            ctrl_d.is_store  = 1'b1;
            ctrl_d.data_wr   = 1'b1;
            ctrl_d.op2sel    = 1'b1;
            ctrl_d.alu_func  = OP_ADD;
            ctrl_d.data_byte = mem_size(instr_funct3_i[1:0]);
            if (instr_funct3_i > 3'd2)
                illegal = 1'b1;
        end else if (is_b_type_i) begin
            ctrl_d.is_branch = 1'b1;
            ctrl_d.op1sel    = 1'b1;
            ctrl_d.op2sel    = 1'b1;
            ctrl_d.alu_func  = OP_ADD;
        end else if (is_u_type_i) begin
            ctrl_d.op2sel = 1'b1;
            ctrl_d.alu_func = OP_ADD;
            if (instr_opcode_i == OPC_LUI) begin
                ctrl_d.rf_wr_data = RF_IMM;
            end else begin
                ctrl_d.op1sel     = 1'b1;
                ctrl_d.rf_wr_data = RF_ALU;
            end
        end else if (is_j_type_i) begin
            ctrl_d.pc_sel     = 1'b1;
            ctrl_d.op1sel     = 1'b1;
            ctrl_d.op2sel     = 1'b1;
            ctrl_d.alu_func   = OP_ADD;
            ctrl_d.rf_wr_data = RF_PC;
        end
    end

`ifdef YARP_MC_TIMEOUT_EN
    localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [WAIT_W-1:0] wait_cnt;

    // Counter is zero on every entry to FETCH/MEM because any non-waiting cycle clears it.
    always_ff @(posedge clk) begin
        if (reset)
            wait_cnt <= '0;
        else if ((state == FETCH && !instr_gnt_i) || (state == MEM && !data_gnt_i))
            wait_cnt <= wait_cnt + 1'b1;
        else
            wait_cnt <= '0;
    end

    assign timeout = (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // Every output is forced low during reset so an aborted instruction writes nothing.
    assign show_ctrl    = !reset && (state == EXEC || state == MEM || state == WB);
    assign instr_req_o  = !reset && state == FETCH;
    assign ir_wr_en_o   = instr_req_o && instr_gnt_i;
    assign data_req_o   = !reset && state == MEM;
    assign rf_wr_en_o   = !reset && state == WB;
    assign pc_wr_en_o   = !reset && (state == WB
                                     || (state == EXEC && ctrl.is_branch)
                                     || (state == MEM && data_gnt_i && ctrl.is_store));
    assign pc_sel_o     = show_ctrl && (ctrl.is_branch ? (state == EXEC && branch_taken_i) : ctrl.pc_sel);
    assign op1sel_o     = show_ctrl && ctrl.op1sel;
    assign op2sel_o     = show_ctrl && ctrl.op2sel;
    assign data_wr_o    = show_ctrl && ctrl.data_wr;
    assign zero_extnd_o = show_ctrl && ctrl.zero_extnd;
    assign alu_func_o   = show_ctrl ? ctrl.alu_func   : 4'd0;
    assign rf_wr_data_o = show_ctrl ? ctrl.rf_wr_data : 2'd0;
    assign data_byte_o  = show_ctrl ? ctrl.data_byte  : 2'd0;
    assign state_o      = state;
    assign fault_o      = !reset && state == TRAP;
    assign retire_cnt_o = retire_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            ctrl       <= '0;
            retire_cnt <= '0;
        end else begin
            if (pc_wr_en_o)
                retire_cnt <= retire_cnt + CNT_W'(1);
            case (state)
                FETCH: begin
                    if (instr_gnt_i)
                        state <= DECODE;
                    else if (timeout)
                        state <= TRAP;
                end
                DECODE: begin
                    if (illegal) begin
                        state <= TRAP;
                    end else begin
                        ctrl  <= ctrl_d;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (ctrl.is_load || ctrl.is_store) begin
                        state <= MEM;
                    end else if (ctrl.is_branch) begin
                        ctrl  <= '0;
                        state <= FETCH;
                    end else begin
                        state <= WB;
                    end
                end
                MEM: begin
                    if (data_gnt_i) begin
                        if (ctrl.is_store) begin
                            ctrl  <= '0;
                            state <= FETCH;
                        end else begin
                            state <= WB;
                        end
                    end else if (timeout) begin
                        ctrl  <= '0;
                        state <= TRAP;
                    end
                end
                WB: begin
                    ctrl  <= '0;
                    state <= FETCH;
                end
                default: state <= TRAP;
            endcase
        end
    end

endmodule
